// File: rtl/edge_binarizer.sv
`default_nettype none
// ============================================================================
// edge_binarizer : thresholds Sobel magnitudes into a 0x00/0xFF edge map with
//                  raster flags and a per-frame edge-pixel count.  Rev 1.0
// ============================================================================
module edge_binarizer #(
    parameter int          IMG_WIDTH      = 256,
    parameter int          IMG_HEIGHT     = 256,
    parameter logic [7:0]  DEFAULT_THRESH = 8'd100,
    parameter int          COUNT_W        = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         pixel_in,
    input  logic               valid_in,
    input  logic [7:0]         thresh_in,
    input  logic               thresh_load,
    output logic [7:0]         pixel_out,
    output logic               valid_out,
    output logic               sof_out,
    output logic               eol_out,
    output logic               eof_out,
    output logic [COUNT_W-1:0] edge_count,
    output logic               count_valid
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [COUNT_W-1:0] run_count;
    logic [7:0]         shadow_thresh;
    logic [7:0]         active_thresh;
    logic [7:0]         frame_thresh;
    logic               first_pixel;
    logic               last_col;
    logic               last_pixel;
    logic               is_edge;

    // The first pixel of a frame bypasses the active register so that a
    // coincident thresh_load already applies to it.
    always_comb begin
        first_pixel  = (state == WAIT_SOF);
        frame_thresh = active_thresh;
        if (first_pixel) begin
            frame_thresh = thresh_load ? thresh_in : shadow_thresh;
        end
        is_edge    = (pixel_in >= frame_thresh);
        last_col   = (col == COL_LAST);
        last_pixel = last_col && (row == ROW_LAST);
    end

    always_comb begin
        state_next = state;
        if (valid_in) begin
            case (state)
                WAIT_SOF: state_next = last_pixel ? WAIT_SOF : IN_FRAME;
                IN_FRAME: state_next = last_pixel ? WAIT_SOF : IN_FRAME;
                default:  state_next = WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_SOF;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_thresh <= DEFAULT_THRESH;
            active_thresh <= DEFAULT_THRESH;
        end else begin
            if (thresh_load) begin
                shadow_thresh <= thresh_in;
            end
            if (valid_in && first_pixel) begin
                active_thresh <= frame_thresh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (last_col) begin
                col <= '0;
                row <= last_pixel ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_out <= 8'h00;
            valid_out <= 1'b0;
            sof_out   <= 1'b0;
            eol_out   <= 1'b0;
            eof_out   <= 1'b0;
        end else begin
            valid_out <= valid_in;
            sof_out   <= valid_in && first_pixel;
            eol_out   <= valid_in && last_col;
            eof_out   <= valid_in && last_pixel;
            if (valid_in) begin
                pixel_out <= is_edge ? 8'hFF : 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_count   <= '0;
            edge_count  <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= valid_in && last_pixel;
            if (valid_in) begin
                if (last_pixel) begin
                    edge_count <= run_count + COUNT_W'(is_edge);
                    run_count  <= '0;
                end else begin
                    run_count  <= run_count + COUNT_W'(is_edge);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_binarizer.sv
`default_nettype none
// ============================================================================
// tb_edge_binarizer : directed bench for edge_binarizer on a 4x3 frame with a
//                     per-cycle reference model.  Rev 1.0
// ============================================================================
module tb_edge_binarizer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    pixel_in = 8'd0;
    logic          valid_in = 1'b0;
    logic [7:0]    thresh_in = 8'd0;
    logic          thresh_load = 1'b0;
    logic [7:0]    pixel_out;
    logic          valid_out;
    logic          sof_out;
    logic          eol_out;
    logic          eof_out;
    logic [CW-1:0] edge_count;
    logic          count_valid;

    int tests = 0;
    int fails = 0;
    logic [CW-1:0] got_counts[$];

    edge_binarizer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DEFAULT_THRESH(8'd100), .COUNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in),
        .thresh_in(thresh_in), .thresh_load(thresh_load),
        .pixel_out(pixel_out), .valid_out(valid_out), .sof_out(sof_out),
        .eol_out(eol_out), .eof_out(eof_out), .edge_count(edge_count),
        .count_valid(count_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position as a linear pixel index.
    int            m_idx;
    logic [7:0]    m_shadow, m_active;
    int            m_run;
    logic          e_valid, e_sof, e_eol, e_eof, e_cv;
    logic [7:0]    e_pixel;
    logic [CW-1:0] e_cnt;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_idx = 0; m_shadow = 8'd100; m_active = 8'd100; m_run = 0;
            e_valid = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_cv = 0;
            e_pixel = 8'h00; e_cnt = '0;
        end else begin
            e_valid = valid_in; e_sof = 0; e_eol = 0; e_eof = 0; e_cv = 0;
            if (valid_in) begin
                if (m_idx == 0) m_active = thresh_load ? thresh_in : m_shadow;
                e_pixel = (pixel_in >= m_active) ? 8'hFF : 8'h00;
                e_sof = (m_idx == 0);
                e_eol = ((m_idx % W) == W - 1);
                e_eof = (m_idx == W * H - 1);
                if (pixel_in >= m_active) m_run++;
                if (e_eof) begin
                    e_cnt = CW'(m_run); e_cv = 1; m_run = 0; m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            if (thresh_load) m_shadow = thresh_in;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("valid_out", valid_out, e_valid);
        chk("pixel_out", pixel_out, e_pixel);
        chk("sof_out", sof_out, e_sof);
        chk("eol_out", eol_out, e_eol);
        chk("eof_out", eof_out, e_eof);
        chk("count_valid", count_valid, e_cv);
        chk("edge_count", edge_count, e_cnt);
        if (count_valid === 1'b1) got_counts.push_back(edge_count);
    end

    task automatic px(input logic [7:0] p, input logic tl = 1'b0, input logic [7:0] tv = 8'd0);
        valid_in = 1'b1; pixel_in = p; thresh_load = tl; thresh_in = tv;
        @(negedge clk);
        valid_in = 1'b0; thresh_load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pixel_in = 8'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        int n0;
        // Reset held while valid toggles
        for (int i = 0; i < 4; i++) begin
            valid_in = i[0]; pixel_in = 8'd200;
            @(negedge clk);
            chk("rst_valid", valid_out, 0);
            chk("rst_pixel", pixel_out, 0);
        end
        valid_in = 1'b0;
        #2 rst = 1'b1;
        px(8'd100);
        chk("eq_thresh_pixel", pixel_out, 8'hFF);
        chk("first_sof", sof_out, 1);
        px(8'd99);
        chk("below_thresh_pixel", pixel_out, 8'h00);
        for (int i = 2; i < W * H; i++) px(8'd0);
        idle(1);
        chk("frame0_count", got_counts[$], 1);

        // Full frame, alternating 0/200
        for (int i = 0; i < W * H; i++) begin
            px(i[0] ? 8'd200 : 8'd0);
            chk("full_eol", eol_out, ((i % W) == W - 1) ? 1 : 0);
            chk("full_eof", eof_out, (i == W * H - 1) ? 1 : 0);
        end
        chk("full_count_valid", count_valid, 1);
        chk("full_edge_count", edge_count, 6);

        // Same frame with gaps
        n0 = got_counts.size();
        for (int i = 0; i < W * H; i++) begin
            px(i[0] ? 8'd200 : 8'd0);
            idle($urandom_range(0, 2));
        end
        idle(1);
        chk("gap_pulses", got_counts.size(), n0 + 1);
        chk("gap_count", got_counts[$], 6);

        // Mid-frame threshold load does not affect current frame
        for (int i = 0; i < W * H; i++) begin
            if (i == 5) begin
                px(8'd120, 1'b1, 8'd150);
                chk("midframe_load_pixel", pixel_out, 8'hFF);
            end else begin
                px(8'd120);
            end
        end
        idle(1);
        chk("thresh_frame_count", got_counts[$], 12);
        px(8'd120);
        chk("new_thresh_pixel", pixel_out, 8'h00);
        for (int i = 1; i < W * H; i++) px(8'd0);
        px(8'd20, 1'b1, 8'd10);
        chk("coincident_load_pixel", pixel_out, 8'hFF);
        for (int i = 1; i < W * H; i++) px(8'd5);
        idle(1);
        chk("coincident_count", got_counts[$], 1);

        // Reset mid-frame
        n0 = got_counts.size();
        for (int i = 0; i < 5; i++) px(8'd200);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        idle(2);
        chk("abort_no_pulse", got_counts.size(), n0);
        for (int i = 0; i < W * H; i++) begin
            px((i % 3 == 0) ? 8'd200 : 8'd0);
            if (i == 0) chk("post_rst_sof", sof_out, 1);
        end
        idle(1);
        chk("post_rst_count", got_counts[$], 4);

        // Back-to-back frames: 0, 12, 7 edges
        n0 = got_counts.size();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < W * H; i++) begin
                case (f)
                    0:       px(8'd0);
                    1:       px(8'd255);
                    default: px((i < 7) ? 8'd150 : 8'd50);
                endcase
                if (i == 0) chk("b2b_sof", sof_out, 1);
            end
        end
        idle(2);
        chk("b2b_pulses", got_counts.size(), n0 + 3);
        if (got_counts.size() == n0 + 3) begin
            chk("b2b_count0", got_counts[n0], 0);
            chk("b2b_count1", got_counts[n0 + 1], 12);
            chk("b2b_count2", got_counts[n0 + 2], 7);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
